mux_en_src_launch: RTL

Source-domain (clk1) launch stage that feeds the MUX-enable synchronizer. It accepts words from a clk1 producer over a valid/ready handshake and holds each word stable on `data_out` while driving a level enable `en_out` into the clk2 domain. It completes a four-phase handshake against the destination's acknowledge `ack_in` before accepting the next word. This guarantees the data bus never changes while the destination may be sampling it.

---
 rtl/mux_en_sync_pkg.sv | 22 ++
 rtl/sync_bit.sv | 35 +++
 rtl/mux_en_src_launch.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_en_sync_pkg.sv
// ----------------------------------------------------------------------------
// mux_en_sync_pkg : shared types and defaults for the MUX-enable synchronizer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_en_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } launch_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_HOLD_CYCLES = 3;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit : N-flop single-bit synchronizer, async active-low reset to 0
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mux_en_src_launch.sv
// ----------------------------------------------------------------------------
// mux_en_src_launch : clk1 launch stage holding data stable under a 4-phase en/ack
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_en_src_launch
  import mux_en_sync_pkg::*;
#(
  parameter int width       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic [width-1:0] data_out,
  output logic             en_out,
  input  logic             ack_in,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  launch_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] data_q, data_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             ack_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk1),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    en_d    = en_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          data_d  = in_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end else begin
          // a stale ack from the previous word blocks new launches
          ready_d = ~ack_s;
        end
      end
      LOAD: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = ASSERT;
      end
      ASSERT: begin
        if (cnt_q == CNT_LAST) begin
          if (ack_s) begin
            en_d    = 1'b0;
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready = ready_q;
  assign data_out = data_q;
  assign en_out   = en_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire
